// File: rtl/sparc8_hazard_pkg.sv
// Shared types and encodings for the SPARC8 decode-stage hazard block.
// Holds the shadow-entry layout and the forwarding select codes.
package sparc8_hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } shadow_t;

    localparam int SHADOW_W = $bits(shadow_t);

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow entry {wr, rd, ld} mirroring a register write in flight.
// Cleared by synchronous reset, captures d on edges where load is high.
module hazard_shadow_stage
    import sparc8_hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SHADOW_W-1:0] d,
    output logic [SHADOW_W-1:0] q
);

    // Entry register: reset wins, otherwise capture when loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_interlock_unit.sv
// Decode-stage load-use interlock and operand-forwarding selects.
// Tracks writes in EX/MEM/WB and stalls one cycle on a load-use hazard.
module hazard_interlock_unit
    import sparc8_hazard_pkg::*;
#(
    parameter int REG_W = sparc8_hazard_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_RF_Enable,
    input  logic             ID_Load_Instr,
    output logic             ctrl_mux_select,
    output logic             PC_enable,
    output logic             nPC_enable,
    output logic             IF_ID_enable,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [CNT_W-1:0] stall_count
);

    shadow_t ex_q;
    shadow_t mem_q;
    shadow_t wb_q;
    shadow_t ex_d;

    logic [SHADOW_W-1:0] ex_bits;
    logic [SHADOW_W-1:0] mem_bits;
    logic [SHADOW_W-1:0] wb_bits;

    logic ex_hit1;
    logic ex_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic wb_hit1;
    logic wb_hit2;
    logic load_use;
    logic stall;

    logic [1:0] sel1;
    logic [1:0] sel2;

    function automatic logic hit(
        input shadow_t          e,
        input logic             use_s,
        input logic [REG_W-1:0] s
    );
        return use_s && (s != '0) && e.wr && (e.rd == s);
    endfunction

    function automatic logic [1:0] pick(
        input logic ex_h,
        input logic ex_ld,
        input logic mem_h,
        input logic wb_h
    );
        logic [1:0] r;
        r = FWD_RF;
        unique case (1'b1)
            (ex_h && !ex_ld): r = FWD_EX;
            (!(ex_h && !ex_ld) && mem_h): r = FWD_MEM;
            (!(ex_h && !ex_ld) && !mem_h && wb_h): r = FWD_WB;
            default: r = FWD_RF;
        endcase
        return r;
    endfunction

    assign ex_q  = shadow_t'(ex_bits);
    assign mem_q = shadow_t'(mem_bits);
    assign wb_q  = shadow_t'(wb_bits);

    // Match each source against every in-flight write.
    always_comb begin
        ex_hit1  = hit(ex_q,  ID_uses_rs1, ID_rs1);
        ex_hit2  = hit(ex_q,  ID_uses_rs2, ID_rs2);
        mem_hit1 = hit(mem_q, ID_uses_rs1, ID_rs1);
        mem_hit2 = hit(mem_q, ID_uses_rs2, ID_rs2);
        wb_hit1  = hit(wb_q,  ID_uses_rs1, ID_rs1);
        wb_hit2  = hit(wb_q,  ID_uses_rs2, ID_rs2);
        load_use = ex_q.ld && (ex_hit1 || ex_hit2);
        stall    = !reset && load_use;
    end

    // Youngest producer wins; reset forces register-file operands.
    always_comb begin
        sel1    = pick(ex_hit1, ex_q.ld, mem_hit1, wb_hit1);
        sel2    = pick(ex_hit2, ex_q.ld, mem_hit2, wb_hit2);
        fwd_rs1 = reset ? FWD_RF : sel1;
        fwd_rs2 = reset ? FWD_RF : sel2;
    end

    // Bubble mux and fetch enables; bubble also held during reset.
    always_comb begin
        ctrl_mux_select = !reset && !stall;
        PC_enable       = !stall;
        nPC_enable      = !stall;
        IF_ID_enable    = !stall;
    end

    // Next EX entry: a bubble on stall, r0 writes recorded as no-write.
    always_comb begin
        ex_d = '0;
        if (!stall) begin
            ex_d.wr = ID_RF_Enable && (ID_rd != '0);
            ex_d.rd = ID_rd;
            ex_d.ld = ID_Load_Instr;
        end
    end

    hazard_shadow_stage u_ex (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (ex_d),
        .q     (ex_bits)
    );

    hazard_shadow_stage u_mem (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (ex_bits),
        .q     (mem_bits)
    );

    hazard_shadow_stage u_wb (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (mem_bits),
        .q     (wb_bits)
    );

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_interlock_unit.md
# hazard_interlock_unit

- Decode-stage hazard block for the SPARC8 pipeline.
- Keeps a shadow copy of the register writes in flight in EX, MEM and WB.
- Drives the select of the control-unit bubble mux (1 = pass decoded controls, 0 = insert NOP) and the PC/nPC/IF-ID load enables.
- Produces operand-forwarding selects for the ID-stage source registers.

## Interface
Parameters:
- REG_W, 5, register specifier width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high
- ID_rs1  input  REG_W  source register 1 of instruction in ID
- ID_rs2  input  REG_W  source register 2 of instruction in ID
- ID_rd  input  REG_W  destination register of instruction in ID
- ID_uses_rs1  input  1  instruction reads rs1
- ID_uses_rs2  input  1  instruction reads rs2 (0 when I13=1)
- ID_RF_Enable  input  1  pre-mux register-file write enable
- ID_Load_Instr  input  1  pre-mux load flag
- ctrl_mux_select  output  1  to bubble mux select; 0 inserts NOP
- PC_enable  output  1  PC load enable
- nPC_enable  output  1  nPC load enable
- IF_ID_enable  output  1  IF/ID register load enable
- fwd_rs1  output  2  operand 1 source: 00 RF, 01 EX, 10 MEM, 11 WB
- fwd_rs2  output  2  operand 2 source, same encoding
- stall_count  output  CNT_W  saturating count of stall cycles

## Operation
Shadow state: three entries, EX, MEM and WB, each holding {wr, rd, ld}.
- A write to r0 (rd==0) is recorded with wr=0.

Hazard checks:
- A match on source s (s = rs1 or rs2) requires uses_s=1, s!=0, entry.wr=1 and entry.rd==s.
- Load-use: stall=1 when EX.ld=1 and EX matches rs1 or rs2.
- While stall=1: ctrl_mux_select=0 and PC_enable=nPC_enable=IF_ID_enable=0.
- Otherwise ctrl_mux_select=1 and all three enables are 1.

Forwarding, per source, priority EX > MEM > WB > RF:
- Select 01 if EX matches and EX.ld=0.
- Else 10 if MEM matches.
- Else 11 if WB matches.
- Else 00.
- When stall=1, fwd outputs still follow this rule; the consumer ignores them.

Shadow advance, every rising clk edge with reset=0:
- WB <= MEM
- MEM <= EX
- EX <= stall ? {0, 0, 0} : {ID_RF_Enable & (ID_rd!=0), ID_rd, ID_Load_Instr}

stall_count:
- Increments on each edge where stall=1.
- Holds at 2^CNT_W-1.

Reset, on an edge with reset=1:
- All shadow entries are cleared to {0, 0, 0}.
- stall_count is set to 0.
- This applies mid-stall as well; the pending stall is dropped.
- While reset is high: ctrl_mux_select=0, all enables=1, fwd_rs1=fwd_rs2=00.

After reset deasserts:
- ctrl_mux_select=1, all enables=1, fwd=00, stall_count=0.

## Timing
- stall, the enables, ctrl_mux_select and fwd_* are combinational from the ID inputs and the registered shadow state, valid in the same cycle.
- Shadow state and stall_count update on the rising edge only.
- A load-use hazard gives exactly one stall cycle. On the next cycle the load sits in MEM, the dependent instruction gets fwd=10, and there is no further stall.
- A load whose rd matches neither source never stalls.
- Simultaneous matches in EX, MEM and WB follow the priority above; the youngest producer wins.
- Both sources may match different stages independently.
- A load in EX matching rs1 while an ALU instruction in MEM matches rs2 stalls. After the stall, rs1=10 (load, now in MEM) and rs2=11 (ALU instruction, now in WB).
- stall_count does not wrap.

## Structure
- Shared package sparc8_hazard_pkg holds REG_W, the FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings, and the packed shadow-entry struct {wr, rd, ld}.
- One sub-module, hazard_shadow_stage: a single entry register with synchronous reset and a load input. It is instantiated three times.
- Match and priority logic live in the top level.

## Test plan
- Reset held 2 cycles then released, no writes in flight:
  - during reset: ctrl_mux_select=0, fwd=00
  - after release: ctrl_mux_select=1, all enables=1, stall_count=0
- ALU instruction writes r5, next instruction reads rs1=r5, rs2=r5:
  - following cycle: fwd_rs1=fwd_rs2=01, no stall
- Load to r8, then an instruction reading rs2=r8:
  - exactly one cycle with ctrl_mux_select=0 and PC/nPC/IF_ID enables=0
  - next cycle fwd_rs2=10
  - stall_count=1
- r3 written by instructions now in WB (first), MEM and EX (last); ID reads rs1=r3:
  - fwd_rs1=01
  - with EX replaced by an unrelated write: fwd_rs1=10
- ID reads r0 while EX, MEM and WB all hold writes with rd=0 → fwd=00, no stall.
- Load-use stall active, reset pulsed for one edge:
  - shadow cleared
  - next cycle ctrl_mux_select=1, stall_count=0
- stall_count preset near max with CNT_W=4, 20 load-use stalls → stall_count saturates at 15.
